// File: rtl/irq_priority_arbiter.sv
// -----------------------------------------------------------------------------
// irq_priority_arbiter
//
// Purpose:
//   Sits between the APB interrupt controller and the CPU interrupt port.
//   Picks the highest-priority eligible pending source, a lower prio value
//   meaning a higher priority and ties going to the lower index. It presents
//   that source to the CPU with a req/ack handshake, pulses the source's clear
//   line when the CPU claims it, and tracks in-service interrupts until the
//   CPU signals end-of-interrupt (EOI).
//
// Configuration:
//   `define IRQ_ARB_NESTING_EN to allow preemption. A strictly higher-priority
//   eligible source may interrupt the one in service, up to NEST_DEPTH
//   stacked entries. EOIs must then complete the entries in LIFO order.
//   When the macro is undefined, the in-service stack holds exactly one entry.
//
// Ports:
//   pclk_i       clock, rising edge
//   rst_i        asynchronous active-high reset
//   enable_i     low freezes every register, so the outputs hold
//   pending_i    masked pending vector, one bit per source
//   prio_i       per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   threshold_i  a source is eligible only if its prio <= threshold_i
//   irq_req_o    interrupt request to the CPU
//   irq_id_o     id of the requested source, or of the in-service source
//   irq_prio_o   priority that goes with irq_id_o
//   irq_ack_i    CPU claim, sampled only while irq_req_o is high
//   eoi_i        end-of-interrupt strobe
//   eoi_id_i     id being completed
//   clear_o      one-cycle one-hot clear back to the controller
//   active_o     at least one interrupt is in service
//   eoi_err_o    one-cycle pulse on an illegal or mismatched EOI
// -----------------------------------------------------------------------------
module irq_priority_arbiter #(
    parameter int NUM_IRQ    = 4,
    parameter int PRIO_W     = 3,
    parameter int ID_W       = 2,
    parameter int NEST_DEPTH = 2
) (
    input  logic                      pclk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [NUM_IRQ-1:0]        pending_i,
    input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]         threshold_i,
    output logic                      irq_req_o,
    output logic [ID_W-1:0]           irq_id_o,
    output logic [PRIO_W-1:0]         irq_prio_o,
    input  logic                      irq_ack_i,
    input  logic                      eoi_i,
    input  logic [ID_W-1:0]           eoi_id_i,
    output logic [NUM_IRQ-1:0]        clear_o,
    output logic                      active_o,
    output logic                      eoi_err_o
);

`ifdef IRQ_ARB_NESTING_EN
    localparam int STK_D = NEST_DEPTH;
`else
    // Without nesting the stack holds one entry. NEST_DEPTH is kept in the
    // expression so that the parameter is still referenced in this build.
    localparam int STK_D = 1 + 0 * NEST_DEPTH;
`endif
    localparam int DW = $clog2(STK_D + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t              state_reg, state_next;

    logic [DW-1:0]       depth_reg, depth_next;
    logic [ID_W-1:0]     stk_id_reg   [STK_D];
    logic [PRIO_W-1:0]   stk_prio_reg [STK_D];

    logic [ID_W-1:0]     req_id_reg;
    logic [PRIO_W-1:0]   req_prio_reg;
    logic [NUM_IRQ-1:0]  clear_reg, clear_next;
    logic                eoi_err_reg, eoi_err_next;

    logic                push, pop, latch;
    logic                in_service;
    logic [ID_W-1:0]     top_id;
    logic [PRIO_W-1:0]   top_prio;

    logic [PRIO_W-1:0]   prio_arr [NUM_IRQ];
    logic [NUM_IRQ-1:0]  eligible;
    logic                any_elig;
    logic [ID_W-1:0]     win_id;
    logic [PRIO_W-1:0]   win_prio;

    assign in_service = (depth_reg != '0);

    // The top of the stack is the entry just below depth_reg. An empty stack
    // reads as zero, so the id and prio outputs come out of reset as zero.
    always_comb begin
        top_id   = '0;
        top_prio = '0;
        for (int i = 0; i < STK_D; i++) begin
            if (depth_reg == DW'(i + 1)) begin
                top_id   = stk_id_reg[i];
                top_prio = stk_prio_reg[i];
            end
        end
    end

    // Per-source eligibility. While a source is in service, only a strictly
    // higher priority than the top entry can compete.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign prio_arr[gi] = prio_i[gi*PRIO_W +: PRIO_W];
            assign eligible[gi] = pending_i[gi]
                               && (prio_arr[gi] <= threshold_i)
                               && (!in_service || (prio_arr[gi] < top_prio));
        end
    endgenerate

    // The scan runs from index 0 upwards and replaces the winner only on a
    // strictly lower prio, so on a tie the lower index keeps the win.
    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        win_prio = '1;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (!any_elig || (prio_arr[i] < win_prio))) begin
                any_elig = 1'b1;
                win_id   = ID_W'(i);
                win_prio = prio_arr[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        depth_next   = depth_reg;
        push         = 1'b0;
        pop          = 1'b0;
        latch        = 1'b0;
        clear_next   = '0;
        eoi_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                eoi_err_next = eoi_i;
                if (any_elig) begin
                    state_next = S_ARB;
                end
            end

            S_ARB: begin
                eoi_err_next = eoi_i;
                if (any_elig) begin
                    latch      = 1'b1;
                    state_next = S_REQ;
                end else begin
                    state_next = in_service ? S_SERVICE : S_IDLE;
                end
            end

            S_REQ: begin
                eoi_err_next = eoi_i;
                // If the ack and a pending drop arrive in the same cycle,
                // the ack is taken.
                if (irq_ack_i && (depth_reg < DW'(STK_D))) begin
                    push       = 1'b1;
                    clear_next = NUM_IRQ'(1) << req_id_reg;
                    state_next = S_SERVICE;
                end else if (!pending_i[req_id_reg]) begin
                    state_next = in_service ? S_SERVICE : S_IDLE;
                end
            end

            S_SERVICE: begin
                if (eoi_i) begin
                    if (eoi_id_i == top_id) begin
                        pop        = 1'b1;
                        state_next = (depth_reg == DW'(1)) ? S_IDLE : S_SERVICE;
                    end else begin
                        eoi_err_next = 1'b1;
                    end
                end
`ifdef IRQ_ARB_NESTING_EN
                // Preemption is only considered in a cycle without an EOI,
                // and only while the stack has room.
                else if (any_elig && (depth_reg < DW'(STK_D))) begin
                    state_next = S_ARB;
                end
`endif
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (push) begin
            depth_next = depth_reg + DW'(1);
        end else if (pop) begin
            depth_next = depth_reg - DW'(1);
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            depth_reg    <= '0;
            req_id_reg   <= '0;
            req_prio_reg <= '0;
            clear_reg    <= '0;
            eoi_err_reg  <= 1'b0;
            for (int i = 0; i < STK_D; i++) begin
                stk_id_reg[i]   <= '0;
                stk_prio_reg[i] <= '0;
            end
        end else if (enable_i) begin
            state_reg   <= state_next;
            depth_reg   <= depth_next;
            clear_reg   <= clear_next;
            eoi_err_reg <= eoi_err_next;
            if (latch) begin
                req_id_reg   <= win_id;
                req_prio_reg <= win_prio;
            end
            for (int i = 0; i < STK_D; i++) begin
                if (push && (depth_reg == DW'(i))) begin
                    stk_id_reg[i]   <= req_id_reg;
                    stk_prio_reg[i] <= req_prio_reg;
                end
            end
        end
    end

    assign irq_req_o  = (state_reg == S_REQ);
    assign irq_id_o   = (state_reg == S_REQ) ? req_id_reg   : top_id;
    assign irq_prio_o = (state_reg == S_REQ) ? req_prio_reg : top_prio;
    assign clear_o    = clear_reg;
    assign active_o   = in_service;
    assign eoi_err_o  = eoi_err_reg;

endmodule
